// File: rtl/detector_jogada.sv
// detector_jogada: input stage of the memory game.
// Debounces the raw 4-bit switch bank, registers each stable one-hot press
// on `jogada` with a one-cycle `jogada_feita` pulse, and requires a debounced
// full release before another press can be accepted.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-low reset
//   habilita         1 = presses are accepted
//   chaves[3:0]      raw switches (may bounce)
//   jogada[3:0]      last accepted one-hot play (registered)
//   jogada_feita     one-cycle pulse, new value on jogada
//   jogada_invalida  one-cycle pulse on a stable non-one-hot press
//   db_tem_jogada    OR of raw chaves
//   db_estado[3:0]   current state code, zero-extended
//
// Optional feature macro: JOGADA_INVALIDA_EN (adds the INVALIDA state).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ESPERA   | idle, waiting for a press with habilita=1
// FILTRA   | same nonzero pattern must repeat DEBOUNCE_CYCLES samples
// REGISTRA | one cycle, jogada updated, jogada_feita high
// SOLTA    | waiting for DEBOUNCE_CYCLES consecutive zero samples
// INVALIDA | one cycle, jogada_invalida high (JOGADA_INVALIDA_EN only)

module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int CNT_W           = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] chaves,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       jogada_invalida,
   output logic       db_tem_jogada,
   output logic [3:0] db_estado
);

   typedef enum logic [2:0] {
      ESPERA   = 3'd0,
      FILTRA   = 3'd1,
      REGISTRA = 3'd2,
      SOLTA    = 3'd3,
      INVALIDA = 3'd4
   } estado_t;

   localparam logic [CNT_W-1:0] DC_W  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] ONE_W = CNT_W'(1);

   estado_t          state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       jogada_q, jogada_d;

   logic             tem_chave;
   logic             cand_onehot;
   logic             chaves_onehot;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_done;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   assign tem_chave     = |chaves;
   assign cand_onehot   = is_onehot(cand_q);
   assign chaves_onehot = is_onehot(chaves);
   // saturating increment; the terminal compare uses the incremented value so
   // the transition happens on the DEBOUNCE_CYCLES-th matching sample
   assign cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + ONE_W;
   assign cnt_done      = (cnt_inc >= DC_W);

   // state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ESPERA;
         cand_q   <= 4'b0000;
         cnt_q    <= '0;
         jogada_q <= 4'b0000;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         jogada_q <= jogada_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      jogada_d = jogada_q;
      unique case (state_q)
         ESPERA: begin
            if (tem_chave && !habilita) begin
               state_d = SOLTA;
               cnt_d   = '0;
            end else if (tem_chave) begin
               cand_d = chaves;
               cnt_d  = ONE_W;
               if (DEBOUNCE_CYCLES == 1) begin
                  // first sample already satisfies the filter
                  if (chaves_onehot) begin
                     jogada_d = chaves;
                     state_d  = REGISTRA;
                  end else begin
`ifdef JOGADA_INVALIDA_EN
                     state_d = INVALIDA;
`else
                     state_d = SOLTA;
                     cnt_d   = '0;
`endif
                  end
               end else begin
                  state_d = FILTRA;
               end
            end
         end
         FILTRA: begin
            if (!habilita) begin
               state_d = tem_chave ? SOLTA : ESPERA;
               cnt_d   = '0;
            end else if (!tem_chave) begin
               state_d = ESPERA;
               cnt_d   = '0;
            end else if (chaves != cand_q) begin
               cand_d = chaves;
               cnt_d  = ONE_W;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_done) begin
                  if (cand_onehot) begin
                     jogada_d = cand_q;
                     state_d  = REGISTRA;
                  end else begin
`ifdef JOGADA_INVALIDA_EN
                     state_d = INVALIDA;
`else
                     state_d = SOLTA;
                     cnt_d   = '0;
`endif
                  end
               end
            end
         end
         REGISTRA: begin
            state_d = SOLTA;
            cnt_d   = '0;
         end
         INVALIDA: begin
            state_d = SOLTA;
            cnt_d   = '0;
         end
         SOLTA: begin
            if (tem_chave) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_done) begin
                  state_d = ESPERA;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ESPERA;
            cnt_d   = '0;
         end
      endcase
   end

   // Moore outputs
   always_comb begin
      jogada        = jogada_q;
      jogada_feita  = (state_q == REGISTRA);
`ifdef JOGADA_INVALIDA_EN
      jogada_invalida = (state_q == INVALIDA);
`else
      jogada_invalida = 1'b0;
`endif
      db_tem_jogada = tem_chave;
      db_estado     = {1'b0, state_q};
   end

endmodule
